// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pkg
// Brief    : Shared coordinate/pixel types and rasteriser state encoding.
// Revision : 1.0
// ============================================================================
package gfx_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } rect_state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

endpackage
`default_nettype wire

// File: rtl/rect_fill_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_engine_if
// Brief    : Command handshake plus frame-buffer write port of the rasteriser.
// Revision : 1.0
// ============================================================================
interface rect_fill_engine_if;
    import gfx_pkg::*;

    logic   cmd_valid;
    logic   cmd_ready;
    coord_t cmd_x0;
    coord_t cmd_y0;
    coord_t cmd_x1;
    coord_t cmd_y1;
    pixel_t cmd_color;
    logic   gpu_access;
    coord_t gpu_x;
    coord_t gpu_y;
    pixel_t gpu_data;
    logic   gpu_we;
    logic   busy;
    logic   done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, gpu_access, gpu_x, gpu_y, gpu_data, gpu_we, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, gpu_access, gpu_x, gpu_y, gpu_data, gpu_we, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/rect_clip_normalize.sv
`default_nettype none
// ============================================================================
// Module   : rect_clip_normalize
// Brief    : Orders two corners into min/max bounds; screen clipping when
//            RECT_FILL_CLIP_EN is defined.
// Revision : 1.0
// ============================================================================
module rect_clip_normalize
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t xmin,
    output coord_t xmax,
    output coord_t ymin,
    output coord_t ymax,
    output logic   empty
);

    coord_t w_xlo, w_xhi, w_ylo, w_yhi;

    if (SCREEN_W < 1 || SCREEN_W > 1024 || SCREEN_H < 1 || SCREEN_H > 1024) begin : g_bad_screen
        $error("rect_clip_normalize: screen size must fit 10-bit coordinates");
    end

    always_comb begin
        w_xlo = (x0 < x1) ? x0 : x1;
        w_xhi = (x0 < x1) ? x1 : x0;
        w_ylo = (y0 < y1) ? y0 : y1;
        w_yhi = (y0 < y1) ? y1 : y0;
    end

`ifdef RECT_FILL_CLIP_EN
    localparam coord_t C_X_LAST = coord_t'(SCREEN_W - 1);
    localparam coord_t C_Y_LAST = coord_t'(SCREEN_H - 1);

    always_comb begin
        xmin  = w_xlo;
        ymin  = w_ylo;
        xmax  = (w_xhi > C_X_LAST) ? C_X_LAST : w_xhi;
        ymax  = (w_yhi > C_Y_LAST) ? C_Y_LAST : w_yhi;
        empty = (w_xlo > C_X_LAST) || (w_ylo > C_Y_LAST);
    end
`else
    always_comb begin
        xmin  = w_xlo;
        ymin  = w_ylo;
        xmax  = w_xhi;
        ymax  = w_yhi;
        empty = 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_engine
// Brief    : Row-major filled-rectangle rasteriser into the frame-buffer write
//            port. Optional clipping macro: RECT_FILL_CLIP_EN.
// Revision : 1.0
// ============================================================================
module rect_fill_engine
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int RD_WAIT  = 1
) (
    input  logic                gpu_clk,
    input  logic                reset,
    rect_fill_engine_if.slave   bus
);

    localparam int                    C_WAIT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [C_WAIT_W-1:0]   C_WAIT_LAST = C_WAIT_W'(RD_WAIT - 1);

    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("rect_fill_engine: RD_WAIT must be at least 1");
    end

    rect_state_t            r_state, w_next;
    logic [C_WAIT_W-1:0]    r_wait;
    coord_t                 r_x0, r_y0, r_x1, r_y1;
    pixel_t                 r_color;
    coord_t                 r_gpu_x, r_gpu_y;
    coord_t                 w_xmin, w_xmax, w_ymin, w_ymax;
    logic                   w_empty;
    logic                   w_more;

    rect_clip_normalize #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .x0    (r_x0),
        .y0    (r_y0),
        .x1    (r_x1),
        .y1    (r_y1),
        .xmin  (w_xmin),
        .xmax  (w_xmax),
        .ymin  (w_ymin),
        .ymax  (w_ymax),
        .empty (w_empty)
    );

    assign w_more = (r_gpu_x < w_xmax) || (r_gpu_y < w_ymax);

    always_ff @(posedge gpu_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.cmd_ready  = 1'b0;
        bus.gpu_access = 1'b0;
        bus.gpu_we     = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) w_next = LOAD;
            end
            LOAD:  w_next = w_empty ? DONE : SETUP;
            SETUP: begin
                bus.gpu_access = 1'b1;
                if (r_wait == C_WAIT_LAST) w_next = WRITE;
            end
            WRITE: begin
                bus.gpu_access = 1'b1;
                bus.gpu_we     = 1'b1;
                w_next         = w_more ? SETUP : DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Scan position only advances on a write, so address/data hold through the
    // read-wait window that precedes each strobe.
    always_ff @(posedge gpu_clk or posedge reset) begin
        if (reset) begin
            r_wait  <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_color <= '0;
            r_gpu_x <= '0;
            r_gpu_y <= '0;
        end else begin
            r_wait <= (r_state == SETUP) ? r_wait + 1'b1 : '0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_x0    <= bus.cmd_x0;
                        r_y0    <= bus.cmd_y0;
                        r_x1    <= bus.cmd_x1;
                        r_y1    <= bus.cmd_y1;
                        r_color <= bus.cmd_color;
                    end
                end
                LOAD: begin
                    if (!w_empty) begin
                        r_gpu_x <= w_xmin;
                        r_gpu_y <= w_ymin;
                    end
                end
                WRITE: begin
                    if (r_gpu_x < w_xmax) begin
                        r_gpu_x <= r_gpu_x + 1'b1;
                    end else if (r_gpu_y < w_ymax) begin
                        r_gpu_x <= w_xmin;
                        r_gpu_y <= r_gpu_y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gpu_x    = r_gpu_x;
    assign bus.gpu_y    = r_gpu_y;
    assign bus.gpu_data = r_color;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_fill_engine
// Brief    : Self-checking bench; two engines (RD_WAIT=1 and RD_WAIT=3).
// Revision : 1.0
// ============================================================================
module tb_rect_fill_engine;
    import gfx_pkg::*;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  d;
        logic [31:0] t;
    } wr_t;

    localparam logic [28:0] RST_VEC = {1'b1, 28'b0};

    logic gpu_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 gpu_clk = ~gpu_clk;

    rect_fill_engine_if bus1();
    rect_fill_engine_if bus3();

    rect_fill_engine #(.RD_WAIT(1)) dut1 (.gpu_clk(gpu_clk), .reset(reset), .bus(bus1));
    rect_fill_engine #(.RD_WAIT(3)) dut3 (.gpu_clk(gpu_clk), .reset(reset), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    logic [31:0] cyc = 0;
    always @(posedge gpu_clk) cyc <= cyc + 1;

    wr_t         wr1[$], wr3[$];
    logic [31:0] hs1[$], hs3[$], dn1[$], dn3[$];
    int          perr1 = 0, perr3 = 0;

    // Observe both engines mid-cycle: writes, handshakes, done pulses, protocol rules.
    always @(negedge gpu_clk) begin
        if (bus1.gpu_we) wr1.push_back({bus1.gpu_x, bus1.gpu_y, bus1.gpu_data, cyc});
        if (bus1.cmd_valid && bus1.cmd_ready) hs1.push_back(cyc);
        if (bus1.done) dn1.push_back(cyc);
        if ((bus1.gpu_we && !bus1.gpu_access) || (bus1.busy && bus1.cmd_ready) ||
            (!bus1.busy && bus1.gpu_access)) perr1 <= perr1 + 1;
        if (bus3.gpu_we) wr3.push_back({bus3.gpu_x, bus3.gpu_y, bus3.gpu_data, cyc});
        if (bus3.cmd_valid && bus3.cmd_ready) hs3.push_back(cyc);
        if (bus3.done) dn3.push_back(cyc);
        if ((bus3.gpu_we && !bus3.gpu_access) || (bus3.busy && bus3.cmd_ready) ||
            (!bus3.busy && bus3.gpu_access)) perr3 <= perr3 + 1;
    end

    wr_t         cur_w[$];
    logic [31:0] cur_hs, cur_dn;
    int          exp_x[$], exp_y[$];

    task automatic clear(input bit sel);
        if (sel) begin wr3.delete(); hs3.delete(); dn3.delete(); end
        else     begin wr1.delete(); hs1.delete(); dn1.delete(); end
    endtask

    task automatic drive_cmd(input bit sel, input int x0, input int y0, input int x1,
                             input int y1, input int c);
        if (sel) begin
            bus3.cmd_x0 = 10'(x0); bus3.cmd_y0 = 10'(y0); bus3.cmd_x1 = 10'(x1);
            bus3.cmd_y1 = 10'(y1); bus3.cmd_color = 4'(c); bus3.cmd_valid = 1'b1;
        end else begin
            bus1.cmd_x0 = 10'(x0); bus1.cmd_y0 = 10'(y0); bus1.cmd_x1 = 10'(x1);
            bus1.cmd_y1 = 10'(y1); bus1.cmd_color = 4'(c); bus1.cmd_valid = 1'b1;
        end
    endtask

    task automatic set_valid(input bit sel, input logic v);
        if (sel) bus3.cmd_valid = v; else bus1.cmd_valid = v;
    endtask

    task automatic issue(input bit sel, input int x0, input int y0, input int x1,
                         input int y1, input int c);
        bit ok = 1'b0;
        @(posedge gpu_clk); #1;
        drive_cmd(sel, x0, y0, x1, y1, c);
        for (int i = 0; i < 100; i++) begin
            if ((sel ? bus3.cmd_ready : bus1.cmd_ready) === 1'b1) begin ok = 1'b1; break; end
            @(posedge gpu_clk); #1;
        end
        @(posedge gpu_clk); #1;
        set_valid(sel, 1'b0);
        checks++;
        if (!ok) begin failures++; $display("FAIL issue_ready: cmd_ready got 0, want 1"); end
    endtask

    task automatic wait_done(input bit sel, input int n);
        int i = 0;
        while (((sel ? dn3.size() : dn1.size()) < n) && i < 4000) begin
            @(posedge gpu_clk); #1; i++;
        end
        checks++;
        if ((sel ? dn3.size() : dn1.size()) < n) begin
            failures++;
            $display("FAIL done_timeout: done pulses got %0d, want %0d", sel ? dn3.size() : dn1.size(), n);
        end
    endtask

    // Writes belonging to the k-th command: strictly between its handshake and done.
    task automatic load_cur(input bit sel, input int k);
        wr_t         src[$];
        logic [31:0] hq[$], dq[$];
        if (sel) begin src = wr3; hq = hs3; dq = dn3; end
        else     begin src = wr1; hq = hs1; dq = dn1; end
        cur_w.delete(); cur_hs = 0; cur_dn = 0;
        if (hq.size() > k && dq.size() > k) begin
            cur_hs = hq[k]; cur_dn = dq[k];
            foreach (src[i]) if (src[i].t > cur_hs && src[i].t < cur_dn) cur_w.push_back(src[i]);
        end
    endtask

    // Reference: expected pixel list straight from the rectangle definition.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1);
        int xl, xh, yl, yh;
        exp_x.delete(); exp_y.delete();
        xl = (x0 < x1) ? x0 : x1; xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1; yh = (y0 < y1) ? y1 : y0;
`ifdef RECT_FILL_CLIP_EN
        if (xl >= 640 || yl >= 480) return;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
`endif
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                exp_x.push_back(x); exp_y.push_back(y);
            end
    endtask

    task automatic check_rect(input string name, input int rw, input int c);
        int n = exp_x.size();
        checks++;
        if (cur_w.size() !== n) begin
            failures++; $display("FAIL %s_count: writes got %0d, want %0d", name, cur_w.size(), n);
        end
        checks++;
        if (int'(cur_dn - cur_hs) !== 2 + n * (rw + 1)) begin
            failures++;
            $display("FAIL %s_latency: got %0d, want %0d", name, int'(cur_dn - cur_hs), 2 + n * (rw + 1));
        end
        for (int j = 0; j < n && j < cur_w.size(); j++) begin
            checks++;
            if ({cur_w[j].x, cur_w[j].y, cur_w[j].d} !== {10'(exp_x[j]), 10'(exp_y[j]), 4'(c)}) begin
                failures++;
                $display("FAIL %s_pix%0d: got (%0d,%0d,%h), want (%0d,%0d,%h)", name, j,
                         cur_w[j].x, cur_w[j].y, cur_w[j].d, exp_x[j], exp_y[j], 4'(c));
            end
            checks++;
            if (cur_w[j].t !== cur_hs + 32'(2 + rw + j * (rw + 1))) begin
                failures++;
                $display("FAIL %s_time%0d: got %0d, want %0d", name, j,
                         int'(cur_w[j].t - cur_hs), 2 + rw + j * (rw + 1));
            end
        end
    endtask

    task automatic run_rect(input bit sel, input string name, input int x0, input int y0,
                            input int x1, input int y1, input int c);
        int p0 = sel ? perr3 : perr1;
        clear(sel);
        issue(sel, x0, y0, x1, y1, c);
        wait_done(sel, 1);
        load_cur(sel, 0);
        build_model(x0, y0, x1, y1);
        check_rect(name, sel ? 3 : 1, c);
        checks++;
        if ((sel ? perr3 : perr1) !== p0) begin
            failures++; $display("FAIL %s_protocol: violations got %0d, want 0", name, (sel ? perr3 : perr1) - p0);
        end
    endtask

    task automatic test_reset;
        logic [28:0] got;
        repeat (3) @(posedge gpu_clk); #1;
        got = {bus1.cmd_ready, bus1.gpu_access, bus1.gpu_x, bus1.gpu_y, bus1.gpu_data,
               bus1.gpu_we, bus1.busy, bus1.done};
        checks++;
        if (got !== RST_VEC) begin failures++; $display("FAIL reset_dut1: got %h, want %h", got, RST_VEC); end
        got = {bus3.cmd_ready, bus3.gpu_access, bus3.gpu_x, bus3.gpu_y, bus3.gpu_data,
               bus3.gpu_we, bus3.busy, bus3.done};
        checks++;
        if (got !== RST_VEC) begin failures++; $display("FAIL reset_dut3: got %h, want %h", got, RST_VEC); end
        reset = 1'b0;
        repeat (2) @(posedge gpu_clk); #1;
        got = {bus1.cmd_ready, bus1.gpu_access, bus1.gpu_x, bus1.gpu_y, bus1.gpu_data,
               bus1.gpu_we, bus1.busy, bus1.done};
        checks++;
        if (got !== RST_VEC) begin failures++; $display("FAIL idle_after_reset: got %h, want %h", got, RST_VEC); end
    endtask

    task automatic test_basic;
        run_rect(1'b0, "basic", 1, 1, 2, 2, 'hA);
        checks++;
        if (int'(cur_dn - cur_hs) !== 10) begin
            failures++; $display("FAIL basic_done10: got %0d, want 10", int'(cur_dn - cur_hs));
        end
    endtask

    task automatic test_swapped;
        run_rect(1'b0, "swapped", 5, 7, 3, 6, 3);
    endtask

    task automatic test_clip_edges;
`ifdef RECT_FILL_CLIP_EN
        run_rect(1'b0, "clip_corner", 638, 478, 700, 500, 6);
        run_rect(1'b0, "clip_offx", 640, 0, 650, 5, 2);
        run_rect(1'b0, "clip_offy", 5, 480, 6, 490, 2);
`else
        run_rect(1'b0, "edge_corner", 638, 478, 639, 479, 6);
`endif
        run_rect(1'b0, "max_coord", 1023, 1020, 1020, 1023, 1);
    endtask

    task automatic test_busy_ignore;
        int i  = 0;
        int p0 = perr1;
        clear(1'b0);
        @(posedge gpu_clk); #1;
        drive_cmd(1'b0, 2, 3, 4, 3, 5);
        while (bus1.cmd_ready !== 1'b1 && i < 100) begin @(posedge gpu_clk); #1; i++; end
        @(posedge gpu_clk); #1;
        drive_cmd(1'b0, 10, 10, 11, 11, 9);
        i = 0;
        while (hs1.size() < 2 && i < 500) begin @(posedge gpu_clk); #1; i++; end
        set_valid(1'b0, 1'b0);
        wait_done(1'b0, 2);
        checks++;
        if (hs1.size() !== 2) begin failures++; $display("FAIL busy_hs_count: got %0d, want 2", hs1.size()); end
        checks++;
        if (hs1.size() < 2 || dn1.size() < 1 || hs1[1] !== dn1[0] + 1) begin
            failures++; $display("FAIL busy_second_accept: second accept not the cycle after done (got %0d entries)", hs1.size());
        end
        checks++;
        if (perr1 !== p0) begin failures++; $display("FAIL busy_ready_low: violations got %0d, want 0", perr1 - p0); end
        load_cur(1'b0, 0); build_model(2, 3, 4, 3);     check_rect("busy_a", 1, 5);
        load_cur(1'b0, 1); build_model(10, 10, 11, 11); check_rect("busy_b", 1, 9);
    endtask

    task automatic test_reset_mid;
        int          i = 0;
        int          n_wr, n_dn;
        logic [28:0] got;
        clear(1'b0);
        @(posedge gpu_clk); #1;
        drive_cmd(1'b0, 0, 0, 9, 9, 7);
        @(posedge gpu_clk); #1;
        set_valid(1'b0, 1'b0);
        while (!(wr1.size() >= 3 && bus1.gpu_we === 1'b1) && i < 200) begin @(posedge gpu_clk); #1; i++; end
        checks++;
        if (i >= 200) begin failures++; $display("FAIL reset_mid_reach: writes got %0d, want >=3", wr1.size()); end
        #2 reset = 1'b1;
        #1;
        got = {bus1.cmd_ready, bus1.gpu_access, bus1.gpu_x, bus1.gpu_y, bus1.gpu_data,
               bus1.gpu_we, bus1.busy, bus1.done};
        checks++;
        if (got !== RST_VEC) begin failures++; $display("FAIL reset_mid_async: got %h, want %h", got, RST_VEC); end
        n_wr = wr1.size(); n_dn = dn1.size();
        repeat (2) @(posedge gpu_clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge gpu_clk); #1;
        checks++;
        if (wr1.size() !== n_wr) begin failures++; $display("FAIL reset_mid_nowrites: got %0d, want %0d", wr1.size(), n_wr); end
        checks++;
        if (dn1.size() !== n_dn || bus1.busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_discard: done got %0d busy %b, want %0d busy 0", dn1.size(), bus1.busy, n_dn);
        end
    endtask

    task automatic test_single_pixel;
        run_rect(1'b1, "single", 0, 0, 0, 0, 'hF);
    endtask

    task automatic test_random;
        int x0, y0, x1, y1, c;
        bit sel;
        for (int k = 0; k < 10; k++) begin
            sel = (k % 3 == 0);
            x0  = $urandom_range(632, 0);
            y0  = $urandom_range(472, 0);
            x1  = x0 + $urandom_range(6, 0);
            y1  = y0 + $urandom_range(5, 0);
            c   = $urandom_range(15, 0);
            if ($urandom_range(1, 0) == 1) run_rect(sel, "rand", x1, y1, x0, y0, c);
            else                           run_rect(sel, "rand", x0, y1, x1, y0, c);
        end
    endtask

    initial begin
        bus1.cmd_valid = 1'b0; bus1.cmd_x0 = '0; bus1.cmd_y0 = '0; bus1.cmd_x1 = '0;
        bus1.cmd_y1 = '0; bus1.cmd_color = '0;
        bus3.cmd_valid = 1'b0; bus3.cmd_x0 = '0; bus3.cmd_y0 = '0; bus3.cmd_x1 = '0;
        bus3.cmd_y1 = '0; bus3.cmd_color = '0;
        test_reset();
        test_basic();
        test_swapped();
        test_clip_edges();
        test_busy_ignore();
        test_reset_mid();
        test_single_pixel();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
